// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit owning the MIPS HI/LO pair.
// Results are computed from latched operands and committed to HI/LO only
// when the cycle counter expires, so partial results are never visible.
module mult_div_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] inputA,
    input  logic [31:0] inputB,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic [31:0]        op_a;
    logic [31:0]        op_b;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_signed;
    logic [31:0]        num_mag;
    logic [31:0]        den_mag;
    logic [31:0]        den_safe;
    logic [31:0]        uq;
    logic [31:0]        ur;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    // Result datapath: full product/quotient computed from the latched operands.
    // Signed division works on magnitudes, then restores signs so the quotient
    // truncates toward zero and the remainder follows the dividend.
    always_comb begin
        prod_s     = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
        prod_u     = {32'd0, op_a} * {32'd0, op_b};
        div_signed = (op_q == OP_DIV);
        num_mag    = (div_signed && op_a[31]) ? 32'(-op_a) : op_a;
        den_mag    = (div_signed && op_b[31]) ? 32'(-op_b) : op_b;
        den_safe   = (den_mag == 32'd0) ? 32'd1 : den_mag;
        uq         = num_mag / den_safe;
        ur         = num_mag % den_safe;
        res_hi     = 32'd0;
        res_lo     = 32'd0;
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (op_b == 32'd0) begin
                    res_hi = op_a;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_lo = (div_signed && (op_a[31] ^ op_b[31])) ? 32'(-uq) : uq;
                    res_hi = (div_signed && op_a[31]) ? 32'(-ur) : ur;
                end
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

    // Control FSM: accepts ops in IDLE, counts down in RUN, commits at expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= OP_NONE;
            op_a  <= 32'd0;
            op_b  <= 32'd0;
            busy  <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (MDOp)
                            OP_MULT, OP_MULTU: begin
                                op_q  <= MDOp;
                                op_a  <= inputA;
                                op_b  <= inputB;
                                cnt   <= CNT_W'(MUL_CYCLES);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q  <= MDOp;
                                op_a  <= inputA;
                                op_b  <= inputB;
                                cnt   <= CNT_W'(DIV_CYCLES);
                                busy  <= 1'b1;
                                state <= RUN;
                            end
                            OP_MTHI: HI <= inputA;
                            OP_MTLO: LO <= inputA;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        HI    <= res_hi;
                        LO    <= res_lo;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
